// File: rtl/seg_msg_scan.sv
// Multiplexed 7-segment message display with a frame-latched message,
// blink gating and a retriggerable buzzer timer.
module seg_msg_scan #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_CYCLES = 50_000,
  parameter int BUZZ_CYCLES    = 100_000_000,
  parameter int BLINK_CYCLES   = 25_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  buzz,
  input  logic [2:0]            state,
  input  logic                  blink_en,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] digit,
  output logic                  buzzer
);

  localparam int RW = $clog2(REFRESH_CYCLES);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int ZW = $clog2(BUZZ_CYCLES + 1);

  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [ZW-1:0] BUZ_LOAD = ZW'(BUZZ_CYCLES);

  logic [RW-1:0] ref_q, ref_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [2:0]    msg_q, msg_d;
  logic [BW-1:0] blk_q, blk_d;
  logic          on_q, on_d;
  logic [ZW-1:0] bcnt_q, bcnt_d;
  logic          buzzer_q, buzzer_d;

  logic          ref_wrap;
  logic [3:0]    idx_w;
  logic [31:0]   row;
  logic [7:0]    seg_raw;

  function automatic logic [31:0] msg_row(input logic [2:0] m);
    case (m)
      3'b001:  msg_row = {8'hFD, 8'h61, 8'hF5, 8'hF5};
      3'b010:  msg_row = {8'hFD, 8'h03, 8'h13, 8'hFD};
      3'b011:  msg_row = {8'hFD, 8'h03, 8'h71, 8'h71};
      3'b100:  msg_row = {8'h03, 8'h31, 8'h61, 8'h13};
      default: msg_row = 32'hFFFF_FFFF;
    endcase
  endfunction

  always_comb begin
    ref_wrap = (ref_q == REF_LAST);
    ref_d    = ref_wrap ? '0 : ref_q + RW'(1);
    idx_d    = idx_q;
    msg_d    = msg_q;
    if (ref_wrap) begin
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
        msg_d = state;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end

    blk_d = blk_q;
    on_d  = on_q;
    if (!blink_en) begin
      blk_d = '0;
      on_d  = 1'b1;
    end else if (blk_q == BLK_LAST) begin
      blk_d = '0;
      on_d  = ~on_q;
    end else begin
      blk_d = blk_q + BW'(1);
    end

    bcnt_d = bcnt_q;
    if (buzz) begin
      bcnt_d = BUZ_LOAD;
    end else if (bcnt_q != '0) begin
      bcnt_d = bcnt_q - ZW'(1);
    end
    buzzer_d = (bcnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q    <= '0;
      idx_q    <= '0;
      msg_q    <= 3'b000;
      blk_q    <= '0;
      on_q     <= 1'b1;
      bcnt_q   <= '0;
      buzzer_q <= 1'b0;
    end else begin
      ref_q    <= ref_d;
      idx_q    <= idx_d;
      msg_q    <= msg_d;
      blk_q    <= blk_d;
      on_q     <= on_d;
      bcnt_q   <= bcnt_d;
      buzzer_q <= buzzer_d;
    end
  end

  // Glyph table covers positions 0..3; wider displays blank the rest.
  always_comb begin
    idx_w   = 4'(idx_q);
    row     = msg_row(msg_q);
    seg_raw = 8'hFF;
    if (idx_w[3:2] == 2'b00) begin
      seg_raw = row[{idx_w[1:0], 3'b000} +: 8];
    end
    seg   = (blink_en && !on_q) ? 8'hFF : seg_raw;
    digit = NUM_DIGITS'(1) << idx_q;
  end

  assign buzzer = buzzer_q;

endmodule

// File: tb/tb_seg_msg_scan.sv
// Scoreboard bench for seg_msg_scan with small timing parameters.
module tb_seg_msg_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       buzz = 1'b0;
  logic [2:0] state = 3'b000;
  logic       blink_en = 1'b0;
  logic [7:0] seg;
  logic [3:0] digit;
  logic       buzzer;

  int checks = 0;
  int failures = 0;

  logic [11:0] sb_q[$];
  logic        bz_q[$];

  seg_msg_scan #(
    .NUM_DIGITS(4),
    .REFRESH_CYCLES(4),
    .BUZZ_CYCLES(10),
    .BLINK_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .buzz(buzz),
    .state(state),
    .blink_en(blink_en),
    .seg(seg),
    .digit(digit),
    .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [7:0] glyph(input logic [2:0] m, input int i);
    logic [7:0] r[4];
    case (m)
      3'b001:  r = '{8'hF5, 8'hF5, 8'h61, 8'hFD};
      3'b010:  r = '{8'hFD, 8'h13, 8'h03, 8'hFD};
      3'b011:  r = '{8'h71, 8'h71, 8'h03, 8'hFD};
      3'b100:  r = '{8'h13, 8'h61, 8'h31, 8'h03};
      default: r = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    endcase
    return r[i];
  endfunction

  function automatic logic [3:0] onehot(input int n);
    logic [3:0] d;
    d = 4'(1 << ((n / 4) % 4));
    return d;
  endfunction

  task automatic cmp_sb(input string name, input int n);
    logic [11:0] e;
    e = sb_q.pop_front();
    checks++;
    if ({digit, seg} !== e) begin
      failures++;
      $display("FAIL %s n=%0d got digit=%b seg=%h want digit=%b seg=%h",
               name, n, digit, seg, e[11:8], e[7:0]);
    end
  endtask

  task automatic test_reset();
    state = 3'b100;
    buzz = 1'b1;
    blink_en = 1'b1;
    rst = 1'b1;
    tick();
    checks++;
    if (digit !== 4'b0001 || seg !== 8'hFF || buzzer !== 1'b0) begin
      failures++;
      $display("FAIL reset got digit=%b seg=%h buzzer=%b want 0001 ff 0",
               digit, seg, buzzer);
    end
    buzz = 1'b0;
    blink_en = 1'b0;
    state = 3'b000;
    rst = 1'b0;
  endtask

  task automatic test_scan();
    state = 3'b000;
    do_reset();
    for (int n = 0; n < 32; n++) begin
      sb_q.push_back({onehot(n), 8'hFF});
      cmp_sb("scan", n);
      tick();
    end
  endtask

  task automatic test_message();
    logic [2:0] m;
    state = 3'b100;
    do_reset();
    for (int n = 0; n < 48; n++) begin
      m = (n < 16) ? 3'b000 : (n < 32) ? 3'b100 : 3'b001;
      sb_q.push_back({onehot(n), glyph(m, (n / 4) % 4)});
      cmp_sb("message", n);
      if (n == 20) state = 3'b001;
      tick();
    end
  endtask

  task automatic test_blink();
    int n;
    state = 3'b011;
    blink_en = 1'b0;
    do_reset();
    for (int i = 0; i < 16; i++) tick();
    blink_en = 1'b1;
    for (int k = 0; k < 60; k++) begin
      n = 16 + k;
      sb_q.push_back({onehot(n),
        (k >= 20 && k < 40) ? 8'hFF : glyph(3'b011, (n / 4) % 4)});
      cmp_sb("blink", k);
      tick();
    end
    sb_q.push_back({onehot(76), 8'hFF});
    cmp_sb("blink_off60", 60);
    blink_en = 1'b0;
    tick();
    sb_q.push_back({onehot(77), glyph(3'b011, (77 / 4) % 4)});
    cmp_sb("blink_drop", 61);
  endtask

  task automatic run_buzz(input logic [31:0] mask, input int want,
                          input string name);
    int cnt;
    int highs;
    logic e;
    state = 3'b000;
    buzz = 1'b0;
    do_reset();
    cnt = 0;
    highs = 0;
    for (int k = 0; k < 30; k++) begin
      buzz = mask[k];
      if (buzz) cnt = 10;
      else if (cnt > 0) cnt--;
      bz_q.push_back(cnt != 0);
      tick();
      e = bz_q.pop_front();
      checks++;
      if (buzzer !== e) begin
        failures++;
        $display("FAIL %s k=%0d got buzzer=%b want %b", name, k, buzzer, e);
      end
      if (buzzer === 1'b1) highs++;
    end
    buzz = 1'b0;
    checks++;
    if (highs != want) begin
      failures++;
      $display("FAIL %s_len got %0d high cycles want %0d", name, highs, want);
    end
  endtask

  task automatic test_buzzer();
    run_buzz(32'h0000_0001, 10, "buzz_single");
    run_buzz(32'h0000_0041, 16, "buzz_retrig");
    run_buzz(32'h0000_001F, 14, "buzz_held");
  endtask

  task automatic test_reset_mid();
    state = 3'b100;
    buzz = 1'b0;
    do_reset();
    for (int n = 0; n < 9; n++) begin
      buzz = (n == 3);
      tick();
    end
    buzz = 1'b0;
    checks++;
    if (digit !== 4'b0100 || buzzer !== 1'b1) begin
      failures++;
      $display("FAIL pre_rst got digit=%b buzzer=%b want 0100 1",
               digit, buzzer);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (digit !== 4'b0001 || seg !== 8'hFF || buzzer !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst got digit=%b seg=%h buzzer=%b want 0001 ff 0",
               digit, seg, buzzer);
    end
  endtask

  task automatic test_unknown();
    state = 3'b111;
    do_reset();
    for (int n = 0; n < 48; n++) begin
      sb_q.push_back({onehot(n), 8'hFF});
      cmp_sb("unknown", n);
      tick();
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_scan();
    test_message();
    test_blink();
    test_buzzer();
    test_reset_mid();
    test_unknown();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_msg_scan.md
SEG_MSG_SCAN -- requirements
Module: seg_msg_scan

Parameters
REQ-001 NUM_DIGITS, default 4, number of multiplexed digits; legal range 4..8.
REQ-002 REFRESH_CYCLES, default 50_000, clk cycles each digit is enabled (1 ms at 50 MHz); minimum 2.
REQ-003 BUZZ_CYCLES, default 100_000_000, buzzer on-time in clk cycles; minimum 1.
REQ-004 BLINK_CYCLES, default 25_000_000, clk cycles per blink half-period; minimum 1.

Interface
REQ-005 clk  input  1  system clock, all logic on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 buzz  input  1  buzzer trigger, level-sampled each cycle.
REQ-008 state  input  3  message select code.
REQ-009 blink_en  input  1  when high, the display flashes.
REQ-010 seg  output  8  segment pattern, bit order a..g,dp, active-low.
REQ-011 digit  output  NUM_DIGITS  one-hot digit enable, active-high; bit 0 is the rightmost digit.
REQ-012 buzzer  output  1  buzzer drive, active-high.

Function
REQ-013 Refresh counter SHALL count 0..REFRESH_CYCLES-1, then wrap to 0.
- On each wrap, digit index idx SHALL advance by 1.
- idx SHALL wrap from NUM_DIGITS-1 to 0.
REQ-014 digit SHALL equal one-hot(idx) at all times; exactly one bit SHALL be set.
REQ-015 Frame latch msg_q SHALL load state only in the cycle where idx wraps NUM_DIGITS-1 -> 0.
- A state change mid-frame SHALL NOT alter the current frame (no tearing).
REQ-016 Message table, digit 3..0 (left to right); E=0x61, F=0x71, n=0x13, O=0x03, P=0x31, r=0xF5, dash=0xFD, blank=0xFF:
- 3'b001: dash E r r
- 3'b010: dash O n dash
- 3'b011: dash O F F
- 3'b100: O P E n
- all other codes: blank on every digit.
REQ-017 Digits at index >= 4 SHALL show blank.
REQ-018 seg SHALL be the table entry for (msg_q, idx), gated by blink, with the same-cycle coherence as digit; no extra pipeline latency between idx and seg.
REQ-019 Blink counter SHALL count 0..BLINK_CYCLES-1; on each wrap, blink phase SHALL toggle.
- Counter and phase SHALL run only while blink_en=1.
- When blink_en=0, the counter SHALL reset to 0 and phase SHALL be forced to "on".
REQ-020 During blink phase "off", seg SHALL be 0xFF; digit scanning SHALL continue unchanged.
REQ-021 buzz=1 sampled at edge t SHALL:
- load the buzz counter with BUZZ_CYCLES;
- set buzzer=1 from edge t.
REQ-022 Otherwise, while the buzz counter is > 0, it SHALL decrement each cycle.
- buzzer SHALL fall in the cycle the counter reaches 0.
- A single-cycle buzz pulse therefore gives buzzer high for exactly BUZZ_CYCLES cycles.
REQ-023 Retrigger: buzz=1 while buzzer is active SHALL reload BUZZ_CYCLES (extend, not accumulate).
- buzz held high SHALL keep buzzer=1 continuously.
REQ-024 The buzz counter SHALL be wide enough for BUZZ_CYCLES without overflow; all counters SHALL be sized by $clog2 of their terminal value.

Reset
REQ-025 rst=1 at a clock edge SHALL set:
- refresh, blink and buzz counters = 0, idx = 0, msg_q = 3'b000;
- blink phase = on, buzzer = 0;
- hence digit = 1 (bit 0 only) and seg = 0xFF.
REQ-026 rst SHALL override buzz, state and blink_en in the same cycle.
- Reset mid-buzz SHALL clear buzzer at that edge.
REQ-027 After rst deasserts, the first msg_q load SHALL occur at the first idx wrap to 0; the display SHALL be blank until then.

Verification (NUM_DIGITS=4, REFRESH_CYCLES=4, BUZZ_CYCLES=10, BLINK_CYCLES=20)
REQ-028 Scan: reset, then run 32 cycles.
- digit SHALL be 0001 for 4 cycles, then 0010, 0100, 1000, then 0001 again, with period 16.
REQ-029 Message/latch: hold state=3'b100 from reset.
- After the first frame: digit 1000/0100/0010/0001 -> seg 0x03/0x31/0x61/0x13.
- Change state to 3'b001 while digit=0010: seg SHALL stay on the OPEn patterns until digit returns to 0001, and show dash E r r in the next frame.
REQ-030 Blink: blink_en=1 with state=3'b011.
- seg SHALL be 0xFF for cycles 20..39 after enable and valid for 40..59.
- Drop blink_en: seg SHALL be valid the next cycle.
REQ-031 Buzzer: 1-cycle buzz pulse -> buzzer high exactly 10 cycles.
- Second pulse at cycle 6 -> buzzer high 16 cycles total.
- buzz held 5 cycles -> high 14 cycles.
REQ-032 Reset mid-operation: assert rst at buzz-counter=5 with idx=2.
- Next cycle: buzzer=0, digit=0001, seg=0xFF.
- Unknown state 3'b111 -> all digits 0xFF.
